multi_digit_seg_driver: RTL

Multi-digit seven-segment display driver for the parking counter display. It accepts a binary value on a load strobe and converts it to BCD with an iterative shift-add-3 (double-dabble) engine. It then time-multiplexes the digits onto one shared active-low segment bus with active-low digit enables. It also blanks leading zeros and flags values that do not fit in the available digits.

---
 rtl/multi_digit_seg_driver.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/multi_digit_seg_driver.sv
// Multiplexed seven-segment driver for the parking counter display.
// The binary input is converted to BCD bit-serially; the display is scanned one digit at a time.
module multi_digit_seg_driver #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned BIN_WIDTH     = 14,
    parameter int unsigned SCAN_DIV      = 50000,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIN_WIDTH-1:0]  value,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int unsigned BcdW     = 4 * NUM_DIGITS;
    localparam int unsigned BitCntW  = $clog2(BIN_WIDTH + 1);
    localparam int unsigned ScanCntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IdxW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [6:0] SegBlank = 7'b1111111;
    localparam logic [6:0] SegDash  = 7'b0111111;
    localparam logic [6:0] SegZero  = 7'b1000000;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Smallest value that no longer fits in NUM_DIGITS decimal digits.
    localparam logic [63:0] OvfLimit = pow10(NUM_DIGITS);

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } state_e;

    state_e               state_q;
    logic [BIN_WIDTH-1:0] bin_q;
    logic [BcdW-1:0]      work_q;
    logic [BitCntW-1:0]   bits_q;
    logic                 ovf_pend_q;
    logic [BcdW-1:0]      disp_q;
    logic [ScanCntW-1:0]  scan_cnt_q;
    logic [IdxW-1:0]      idx_q;

    logic [BcdW-1:0]       work_adj;
    logic                  value_ovf;
    logic [IdxW-1:0]       idx_nxt;
    logic                  scan_wrap;
    logic [BcdW-1:0]       disp_shift;
    logic [3:0]            sel_nib;
    logic                  upper_zero;
    logic [6:0]            seg_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        work_adj = work_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign value_ovf = (64'(value) >= OvfLimit);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            work_q     <= '0;
            bits_q     <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        bin_q      <= value;
                        work_q     <= '0;
                        bits_q     <= BitCntW'(BIN_WIDTH);
                        ovf_pend_q <= value_ovf;
                        busy       <= 1'b1;
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    // Carry out of the top nibble is dropped; ovf_pend_q covers that case.
                    work_q <= {work_adj[BcdW-2:0], bin_q[BIN_WIDTH-1]};
                    bin_q  <= bin_q << 1;
                    bits_q <= bits_q - 1'b1;
                    if (bits_q == BitCntW'(1)) begin
                        state_q <= StCommit;
                    end
                end
                StCommit: begin
                    disp_q   <= work_q;
                    overflow <= ovf_pend_q;
                    busy     <= 1'b0;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign scan_wrap = (scan_cnt_q == ScanCntW'(SCAN_DIV - 1));

    always_comb begin
        if (idx_q == IdxW'(NUM_DIGITS - 1)) begin
            idx_nxt = '0;
        end else begin
            idx_nxt = idx_q + 1'b1;
        end
    end

    // Selected digit sits in the low nibble; the rest are the more significant digits.
    assign disp_shift = disp_q >> {idx_nxt, 2'b00};
    assign sel_nib    = disp_shift[3:0];
    assign upper_zero = (disp_shift == '0);

    always_comb begin
        seg_nxt = seg_decode(sel_nib);
        if (overflow) begin
            seg_nxt = SegDash;
        end else if ((BLANK_LEADING != 0) && (idx_nxt != '0) && upper_zero) begin
            seg_nxt = SegBlank;
        end
    end

    assign an_nxt = ~(NUM_DIGITS'(1) << idx_nxt);

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
            an         <= ~NUM_DIGITS'(1);
            seg        <= SegZero;
        end else if (scan_wrap) begin
            scan_cnt_q <= '0;
            idx_q      <= idx_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
        end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
        end
    end

endmodule
